imem_fetch_buffer: RTL and testbench
====================================

# imem_fetch_buffer

Parametrised instruction-fetch port between the MIPS core's PC and the shared memory bus. It returns a word-aligned instruction per fetch request. It keeps a small direct-mapped buffer of recently fetched words, so repeat fetches (loops) complete without a bus transaction. It adds a response timeout with error reporting and a flush input for program reload. It replaces the unclocked request/response instruction memory port and uses the same memory-side handshake signals.

## Interface
Parameters:
- `ADDR_W`, 32: PC width in bits (byte address).
- `DATA_W`, 32: instruction width.
- `DEPTH`, 4: buffer entries; power of two, ≥2.
- `TIMEOUT`, 255: maximum cycles in MISS before abort; must be ≥1.
- `CNT_W`, 16: width of the saturating performance counters.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `pc`  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- `fetch_req`  in  1  fetch request; `pc` must stay stable while `stall`=1.
- `flush`  in  1  invalidates all buffer entries.
- `instr`  out  DATA_W  fetched word; valid when `instr_valid`=1.
- `instr_valid`  out  1  one-cycle pulse: `instr` is valid.
- `stall`  out  1  fetch in progress, core must hold.
- `fetch_err`  out  1  one-cycle pulse: timeout abort.
- `hit_count`, `miss_count`  out  CNT_W  saturating counters.
- `memory_addr`  out  32  word-aligned bus address.
- `memory_rden`  out  1  read request, level.
- `memory_read_val`  in  32  bus read data.
- `memory_response`  in  1  bus data valid this cycle.

## Operation
- Buffer entry fields: valid bit, tag, data.
  - Index = `pc[2 +: log2(DEPTH)]`.
  - Tag = `pc[ADDR_W-1 : 2+log2(DEPTH)]`.
- FSM states: IDLE, MISS.
- IDLE with `fetch_req`=1:
  - Hit (entry valid and tag equal): register the data onto `instr` and pulse `instr_valid` next cycle. `hit_count`++. Stay in IDLE.
  - Miss: go to MISS. Latch `pc` and index. Set `memory_addr` = {pc[ADDR_W-1:2], 2'b00}, zero-extended or truncated to 32. `miss_count`++.
- MISS:
  - `memory_rden` is held at 1 until `memory_response` is sampled high.
  - On response: write `memory_read_val[DATA_W-1:0]` into the entry, set it valid, drive `instr`, pulse `instr_valid` next cycle, clear `memory_rden`, return to IDLE.
  - The timeout counter increments each MISS cycle. When it reaches `TIMEOUT` without a response: drop `memory_rden`, pulse `fetch_err`, leave the buffer unchanged, return to IDLE.
- `stall` = `fetch_req` & (state==MISS | lookup cycle in IDLE). It is combinational. It is 0 in the cycle `instr_valid`=1 unless a new request is already being looked up.
- `flush`:
  - Clears all valid bits at the clock edge.
  - When `flush` coincides with the response in MISS: the word is still delivered to the core but not written to the buffer.
  - When `flush` coincides with an IDLE lookup: the lookup uses pre-flush contents.
- `memory_response` is ignored in IDLE, e.g. a late response after a timeout or reset.
- Counters saturate at 2^CNT_W−1.

## Timing
- Reset values:
  - Outputs: `instr`=0, `instr_valid`=0, `stall`=0, `fetch_err`=0, `hit_count`=0, `miss_count`=0, `memory_addr`=0, `memory_rden`=0.
  - Internal: all valid bits cleared, state IDLE, timeout counter 0.
- Hit latency: request in cycle 0 → `instr_valid` in cycle 1.
- Miss latency:
  - Request in cycle 0 → `memory_rden`=1 from cycle 1.
  - Response sampled in cycle k → `instr_valid` in cycle k+1; `memory_rden` low from cycle k+1.
  - Minimum latency is 2 cycles.
- Timeout: with no response, `fetch_err` pulses in cycle TIMEOUT+1 after the request, and `memory_rden` is low in that same cycle.
- Back-to-back: a new request may be looked up in the cycle `instr_valid` is high.
- `reset` mid-MISS: `memory_rden` drops next edge, no `instr_valid`, buffer invalidated.
- `memory_read_val` is sampled only in a cycle where `memory_rden`=1 and `memory_response`=1.

## Test plan
- Cold miss:
  - Stimulus: reset, `pc`=0x40 request, response with 0x8C080004 after 3 cycles.
  - Required: `memory_addr`=0x40; `instr_valid` one cycle after the response with `instr`=0x8C080004; `miss_count`=1.
- Hit after fill:
  - Stimulus: request 0x40 again.
  - Required: `instr_valid` next cycle, same data, no `memory_rden`; `hit_count`=1.
- Conflict eviction (DEPTH=4):
  - Stimulus: fill 0x00, then fetch 0x10 (same index), then 0x00.
  - Required: three misses, each with one `memory_rden` assertion.
- Timeout (TIMEOUT=8):
  - Stimulus: miss with no response for 8 cycles, then a late `memory_response` in IDLE.
  - Required: `fetch_err` pulse, `memory_rden` low; the late response is ignored and the next fetch of the same pc misses.
- Flush during MISS:
  - Stimulus: assert `flush` in the same cycle as the response.
  - Required: the core still gets the data; a refetch of the same pc misses.
- Reset mid-MISS:
  - Stimulus: assert `reset` while `memory_rden`=1.
  - Required: all outputs at reset values next cycle; a previously buffered address misses afterwards.

Source files
------------

// File: rtl/imem_fetch_buffer.sv
// Instruction-fetch port with a small direct-mapped word buffer in front of the
// shared memory bus; misses go to the bus with a bounded wait and error pulse.
module imem_fetch_buffer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              fetch_err,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [31:0]       memory_addr,
  output logic              memory_rden,
  input  logic [31:0]       memory_read_val,
  input  logic              memory_response
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, MISS} state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t             state, state_nxt;
  logic [DEPTH-1:0]   ent_vld;
  entry_t             ent [DEPTH];

  logic [IDX_W-1:0]   lk_idx, miss_idx;
  logic [TAG_W-1:0]   lk_tag, miss_tag;
  logic               lk_hit;
  logic               lookup, resp, tmo;
  logic [TO_W-1:0]    tmo_cnt;
  logic [31:0]        word_addr;
  logic [DATA_W-1:0]  rdata;
  logic               unused_pc_lsb;

  assign unused_pc_lsb = ^pc[1:0];

  // Bus address is the word address, zero-extended or truncated to 32 bits.
  generate
    if (ADDR_W >= 32) begin : g_addr_trunc
      assign word_addr = {pc[31:2], 2'b00};
    end else begin : g_addr_ext
      assign word_addr = {{(32-ADDR_W){1'b0}}, pc[ADDR_W-1:2], 2'b00};
    end
    if (DATA_W <= 32) begin : g_data_trunc
      assign rdata = memory_read_val[DATA_W-1:0];
    end else begin : g_data_ext
      assign rdata = {{(DATA_W-32){1'b0}}, memory_read_val};
    end
  endgenerate

  assign lk_idx = pc[2 +: IDX_W];
  assign lk_tag = pc[ADDR_W-1 -: TAG_W];
  assign lk_hit = ent_vld[lk_idx] && (ent[lk_idx].tag == lk_tag);

  assign lookup = (state == IDLE) && fetch_req;
  assign resp   = (state == MISS) && memory_rden && memory_response;
  // Response in the last allowed cycle still wins over the abort.
  assign tmo    = (state == MISS) && !memory_response &&
                  (tmo_cnt == TO_W'(TIMEOUT - 1));

  assign stall  = lookup || ((state == MISS) && fetch_req);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lookup && !lk_hit) state_nxt = MISS;
      MISS:    if (resp || tmo)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ent_vld     <= '0;
      tmo_cnt     <= '0;
      miss_idx    <= '0;
      miss_tag    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
      memory_addr <= '0;
      memory_rden <= 1'b0;
    end else begin
      state       <= state_nxt;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;

      if (lookup) begin
        if (lk_hit) begin
          instr       <= ent[lk_idx].data;
          instr_valid <= 1'b1;
          if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
        end else begin
          miss_idx    <= lk_idx;
          miss_tag    <= lk_tag;
          memory_addr <= word_addr;
          memory_rden <= 1'b1;
          tmo_cnt     <= '0;
          if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
        end
      end

      if (resp) begin
        instr       <= rdata;
        instr_valid <= 1'b1;
        memory_rden <= 1'b0;
        ent_vld[miss_idx] <= 1'b1;
      end else if (tmo) begin
        memory_rden <= 1'b0;
        fetch_err   <= 1'b1;
      end else if (state == MISS) begin
        tmo_cnt <= tmo_cnt + TO_W'(1);
      end

      // Flush wins over a same-cycle fill; the lookup above already saw old contents.
      if (flush) ent_vld <= '0;
    end
  end

  // Payload needs no reset: it is only observed through ent_vld.
  always_ff @(posedge clk) begin
    if (resp && !flush && !reset) begin
      ent[miss_idx].tag  <= miss_tag;
      ent[miss_idx].data <= rdata;
    end
  end

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Directed + randomized bench for imem_fetch_buffer against a word-address keyed
// buffer model with saturating hit/miss tallies.
module tb_imem_fetch_buffer;
  localparam int TIMEOUT = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       pc = '0;
  logic              fetch_req = 1'b0;
  logic              flush = 1'b0;
  logic [31:0]       instr;
  logic              instr_valid, stall, fetch_err;
  logic [CNT_W-1:0]  hit_count, miss_count;
  logic [31:0]       memory_addr;
  logic              memory_rden;
  logic [31:0]       memory_read_val = '0;
  logic              memory_response = 1'b0;

  imem_fetch_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req), .flush(flush),
    .instr(instr), .instr_valid(instr_valid), .stall(stall), .fetch_err(fetch_err),
    .hit_count(hit_count), .miss_count(miss_count), .memory_addr(memory_addr),
    .memory_rden(memory_rden), .memory_read_val(memory_read_val),
    .memory_response(memory_response)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: each slot remembers the full word address it holds.
  bit          m_vld   [DEPTH];
  logic [29:0] m_waddr [DEPTH];
  logic [31:0] m_data  [DEPTH];
  int          m_hits, m_misses;

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt();
    check("hit_count", 64'(hit_count), 64'(sat(m_hits)));
    check("miss_count", 64'(miss_count), 64'(sat(m_misses)));
  endtask

  task automatic do_reset();
    reset = 1'b1; fetch_req = 1'b0; flush = 1'b0; memory_response = 1'b0;
    tick();
    reset = 1'b0;
    m_clear(); m_hits = 0; m_misses = 0;
    check("rst_instr", 64'(instr), 0);
    check("rst_valid", 64'(instr_valid), 0);
    check("rst_err", 64'(fetch_err), 0);
    check("rst_addr", 64'(memory_addr), 0);
    check("rst_rden", 64'(memory_rden), 0);
    check("rst_stall", 64'(stall), 0);
    check_cnt();
  endtask

  // One fetch; dly >= TIMEOUT means the bus never answers in time.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int dly,
                       input bit fl_look, input bit fl_resp);
    int          ix;
    bit          hit;
    logic [31:0] hdata;
    ix    = int'(a[3:2]) % DEPTH;
    hit   = m_vld[ix] && (m_waddr[ix] == a[31:2]);
    hdata = m_data[ix];
    pc = a; fetch_req = 1'b1; flush = fl_look;
    #1 check("stall_lookup", 64'(stall), 1);
    if (hit) m_hits++; else m_misses++;
    if (fl_look) m_clear();
    tick();
    flush = 1'b0;
    if (hit) begin
      fetch_req = 1'b0;
      check("hit_valid", 64'(instr_valid), 1);
      check("hit_instr", 64'(instr), 64'(hdata));
      check("hit_rden", 64'(memory_rden), 0);
      check_cnt();
      #1 check("hit_stall_after", 64'(stall), 0);
      return;
    end
    check("miss_rden", 64'(memory_rden), 1);
    check("miss_addr", 64'(memory_addr), 64'({a[31:2], 2'b00}));
    check("miss_valid", 64'(instr_valid), 0);
    check_cnt();
    if (dly >= TIMEOUT) begin
      for (int c = 1; c < TIMEOUT; c++) begin
        tick();
        check("tmo_wait_rden", 64'(memory_rden), 1);
        check("tmo_wait_err", 64'(fetch_err), 0);
      end
      tick();
      check("tmo_err", 64'(fetch_err), 1);
      check("tmo_rden", 64'(memory_rden), 0);
      check("tmo_valid", 64'(instr_valid), 0);
      fetch_req = 1'b0;
      memory_response = 1'b1; memory_read_val = d;
      tick();
      memory_response = 1'b0;
      check("late_resp_valid", 64'(instr_valid), 0);
      check("late_resp_err", 64'(fetch_err), 0);
      check("late_resp_rden", 64'(memory_rden), 0);
      return;
    end
    repeat (dly) begin
      tick();
      check("wait_valid", 64'(instr_valid), 0);
      check("wait_rden", 64'(memory_rden), 1);
    end
    memory_response = 1'b1; memory_read_val = d; flush = fl_resp;
    tick();
    memory_response = 1'b0; flush = 1'b0; fetch_req = 1'b0;
    memory_read_val = $urandom;
    check("fill_valid", 64'(instr_valid), 1);
    check("fill_instr", 64'(instr), 64'(d));
    check("fill_rden", 64'(memory_rden), 0);
    check("fill_err", 64'(fetch_err), 0);
    if (fl_resp) m_clear();
    else begin
      m_vld[ix] = 1'b1; m_waddr[ix] = a[31:2]; m_data[ix] = d;
    end
    #1 check("fill_stall_after", 64'(stall), 0);
  endtask

  initial begin
    logic [31:0] a;
    int          r, dly;

    do_reset();

    // Cold miss, then hit of the same word.
    fetch(32'h40, 32'h8C08_0004, 3, 0, 0);
    fetch(32'h40, 32'hDEAD_BEEF, 0, 0, 0);
    check("hit_cnt_one", 64'(hit_count), 1);

    // Same-index conflict: three misses.
    fetch(32'h00, 32'h1111_0000, 1, 0, 0);
    fetch(32'h10, 32'h2222_0010, 0, 0, 0);
    fetch(32'h00, 32'h3333_0000, 2, 0, 0);

    // Timeout with late response, then the same pc must miss.
    fetch(32'h80, 32'hBAD0_0080, TIMEOUT, 0, 0);
    fetch(32'h80, 32'h4444_0080, 1, 0, 0);

    // Flush with the response: data delivered, not kept.
    fetch(32'h24, 32'h5555_0024, 0, 0, 1);
    fetch(32'h24, 32'h6666_0024, TIMEOUT - 1, 0, 0);
    // Flush with a hit lookup: old contents still serve this fetch.
    fetch(32'h24, 32'h0, 0, 1, 0);
    fetch(32'h24, 32'h7777_0024, 0, 0, 0);

    // Reset while the bus read is pending.
    fetch(32'h08, 32'h8888_0008, 0, 0, 0);
    pc = 32'h30; fetch_req = 1'b1;
    tick();
    check("pre_reset_rden", 64'(memory_rden), 1);
    reset = 1'b1; fetch_req = 1'b0;
    tick();
    reset = 1'b0;
    check("midrst_rden", 64'(memory_rden), 0);
    check("midrst_valid", 64'(instr_valid), 0);
    check("midrst_addr", 64'(memory_addr), 0);
    check("midrst_instr", 64'(instr), 0);
    check("midrst_hits", 64'(hit_count), 0);
    check("midrst_misses", 64'(miss_count), 0);
    m_clear(); m_hits = 0; m_misses = 0;
    memory_response = 1'b1; memory_read_val = 32'hFFFF_FFFF;
    tick();
    memory_response = 1'b0;
    check("post_rst_resp_valid", 64'(instr_valid), 0);
    fetch(32'h08, 32'h9999_0008, 0, 0, 0);

    // Randomized traffic over a small address pool to force reuse and conflicts.
    for (int n = 0; n < 80; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) |
          32'($urandom_range(0, 3));
      r = $urandom_range(0, 11);
      dly = (r == 11) ? TIMEOUT : (r % 5);
      fetch(a, $urandom, dly, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 6) == 0) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_clear();
        check("idle_flush_valid", 64'(instr_valid), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
